// File: rtl/mips_isa_pkg.sv
// Shared MIPS subset definitions: mnemonic codes, opcode/funct constants, field widths.
// Also used by instruction_decoder, so keep encodings in sync with it.
package mips_isa_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [OP_W-1:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_AND  = 4'd2,
    MN_OR   = 4'd3,
    MN_ADDI = 4'd4,
    MN_ORI  = 4'd5,
    MN_LW   = 4'd6,
    MN_SW   = 4'd7,
    MN_BEQ  = 4'd8,
    MN_BNE  = 4'd9,
    MN_LUI  = 4'd10
  } mnemonic_e;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OPC_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OPC_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OPC_LUI   = 6'h0F;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;

  function automatic logic [INSTR_W-1:0] pack_r(
    input logic [REG_W-1:0]   rs,
    input logic [REG_W-1:0]   rt,
    input logic [REG_W-1:0]   rd,
    input logic [FUNCT_W-1:0] funct
  );
    return {OPC_RTYPE, rs, rt, rd, {SHAMT_W{1'b0}}, funct};
  endfunction

  function automatic logic [INSTR_W-1:0] pack_i(
    input logic [OPC_W-1:0] opc,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic [IMM_W-1:0] imm
  );
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational encoder: mnemonic plus register/immediate fields -> 32-bit MIPS word.
// Codes outside the mnemonic set flag illegal and produce a zero word.
module instr_field_encoder
  import mips_isa_pkg::*;
(
  input  logic [OP_W-1:0]    op_i,
  input  logic [REG_W-1:0]   rs_i,
  input  logic [REG_W-1:0]   rt_i,
  input  logic [REG_W-1:0]   rd_i,
  input  logic [IMM_W-1:0]   imm_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      MN_ADD:  word_o = pack_r(rs_i, rt_i, rd_i, FUNCT_ADD);
      MN_SUB:  word_o = pack_r(rs_i, rt_i, rd_i, FUNCT_SUB);
      MN_AND:  word_o = pack_r(rs_i, rt_i, rd_i, FUNCT_AND);
      MN_OR:   word_o = pack_r(rs_i, rt_i, rd_i, FUNCT_OR);
      MN_ADDI: word_o = pack_i(OPC_ADDI, rs_i, rt_i, imm_i);
      MN_ORI:  word_o = pack_i(OPC_ORI, rs_i, rt_i, imm_i);
      MN_LW:   word_o = pack_i(OPC_LW, rs_i, rt_i, imm_i);
      MN_SW:   word_o = pack_i(OPC_SW, rs_i, rt_i, imm_i);
      MN_BEQ:  word_o = pack_i(OPC_BEQ, rs_i, rt_i, imm_i);
      MN_BNE:  word_o = pack_i(OPC_BNE, rs_i, rt_i, imm_i);
      // LUI has no source register; the rs field is always zero
      MN_LUI:  word_o = pack_i(OPC_LUI, {REG_W{1'b0}}, rt_i, imm_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Encodes streamed instruction requests and writes them sequentially into instruction memory.
// Optional running XOR checksum of written words when INSTR_LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for the first start pulse after reset
// LOAD  | accepting beats, writing one word per legal beat
// DONE  | last beat seen or memory full; waiting for start
module instr_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_op,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic                in_last,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [INSTR_W-1:0]  mem_wdata,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     word_count,
  output logic                err_illegal,
  output logic                err_overflow
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic [INSTR_W-1:0]  checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [INSTR_W-1:0]   mem_wdata_q;
  logic [ADDR_W:0]      word_count_q;
  logic                 err_illegal_q;
  logic                 err_overflow_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0]   checksum_q;
`endif

  logic [INSTR_W-1:0]   enc_word;
  logic                 enc_illegal;
  logic                 accept;
  logic                 at_last_addr;

  instr_field_encoder u_enc (
    .op_i      (in_op),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .imm_i     (in_imm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  assign accept       = in_valid && (state_q == S_LOAD);
  assign at_last_addr = (addr_q == ADDR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      word_count_q   <= '0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      checksum_q     <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (mem_we_q) begin
        checksum_q <= checksum_q ^ mem_wdata_q;
      end
`endif
      // start wins over any beat presented in the same cycle
      if (start) begin
        state_q        <= S_LOAD;
        addr_q         <= '0;
        mem_addr_q     <= '0;
        word_count_q   <= '0;
        err_illegal_q  <= 1'b0;
        err_overflow_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        checksum_q     <= '0;
`endif
      end else if (accept) begin
        if (enc_illegal) begin
          err_illegal_q <= 1'b1;
          if (in_last) begin
            state_q <= S_DONE;
          end
        end else begin
          mem_we_q     <= 1'b1;
          mem_addr_q   <= addr_q;
          mem_wdata_q  <= enc_word;
          word_count_q <= word_count_q + (ADDR_W+1)'(1);
          if (in_last) begin
            state_q <= S_DONE;
          end else if (at_last_addr) begin
            err_overflow_q <= 1'b1;
            state_q        <= S_DONE;
          end
          // the pointer saturates at the top of memory rather than wrapping
          if (!at_last_addr) begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
      end
    end
  end

  assign in_ready     = (state_q == S_LOAD);
  assign busy         = (state_q == S_LOAD);
  assign done         = (state_q == S_DONE);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign word_count   = word_count_q;
  assign err_illegal  = err_illegal_q;
  assign err_overflow = err_overflow_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign checksum     = checksum_q;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (ADDR_W=2 so memory-full is reachable).
// A behavioural model is compared every cycle; literal words pin the model's encoding.
module tb_instr_loader;
  import mips_isa_pkg::*;

  localparam int AW = 2;
  localparam int MAX_ADDR = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic [AW:0]       word_count;
  logic              err_illegal;
  logic              err_overflow;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  instr_loader #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rs        (in_rs),
    .in_rt        (in_rt),
    .in_rd        (in_rd),
    .in_imm       (in_imm),
    .in_last      (in_last),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .word_count   (word_count),
    .err_illegal  (err_illegal),
    .err_overflow (err_overflow)
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding from the instruction-set table, using plain arithmetic on field positions
  function automatic logic [32:0] m_encode(input int op, input int rs, input int rt,
                                           input int rd, input int imm);
    longint w;
    int opc;
    int fn;
    fn = -1;
    opc = -1;
    case (op)
      0: fn = 'h20;
      1: fn = 'h22;
      2: fn = 'h24;
      3: fn = 'h25;
      4: opc = 'h08;
      5: opc = 'h0D;
      6: opc = 'h23;
      7: opc = 'h2B;
      8: opc = 'h04;
      9: opc = 'h05;
      10: begin opc = 'h0F; rs = 0; end
      default: ;
    endcase
    if (fn >= 0) begin
      w = longint'(rs) * (2 ** 21) + longint'(rt) * (2 ** 16) + longint'(rd) * (2 ** 11) + fn;
      return {1'b0, w[31:0]};
    end else if (opc >= 0) begin
      w = longint'(opc) * (2 ** 26) + longint'(rs) * (2 ** 21) + longint'(rt) * (2 ** 16) + imm;
      return {1'b0, w[31:0]};
    end
    return {1'b1, 32'h0};
  endfunction

  bit          m_loading, m_done, m_we, m_ill, m_ovf;
  int          m_next, m_count, m_addr;
  logic [31:0] m_wdata, m_csum;

  always @(posedge clk or posedge rst) begin : model
    logic [32:0] e;
    if (rst) begin
      m_loading = 0; m_done = 0; m_we = 0; m_ill = 0; m_ovf = 0;
      m_next = 0; m_count = 0; m_addr = 0; m_wdata = 0; m_csum = 0;
    end else begin
      if (m_we) m_csum = m_csum ^ m_wdata;
      m_we = 0;
      if (start) begin
        m_loading = 1; m_done = 0; m_ill = 0; m_ovf = 0;
        m_next = 0; m_count = 0; m_addr = 0; m_csum = 0;
      end else if (m_loading && in_valid) begin
        e = m_encode(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm));
        if (e[32]) begin
          m_ill = 1;
          if (in_last) begin m_loading = 0; m_done = 1; end
        end else begin
          m_we = 1;
          m_addr = m_next;
          m_wdata = e[31:0];
          m_count++;
          if (in_last) begin
            m_loading = 0; m_done = 1;
          end else if (m_next == MAX_ADDR) begin
            m_ovf = 1; m_loading = 0; m_done = 1;
          end
          if (m_next < MAX_ADDR) m_next++;
        end
      end
    end
  end

  logic [31:0] cap [0:MAX_ADDR];
  int          wr_cnt = 0;

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(m_loading));
    check("busy", 32'(busy), 32'(m_loading));
    check("done", 32'(done), 32'(m_done));
    check("mem_we", 32'(mem_we), 32'(m_we));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("word_count", 32'(word_count), 32'(m_count));
    check("err_illegal", 32'(err_illegal), 32'(m_ill));
    check("err_overflow", 32'(err_overflow), 32'(m_ovf));
    if (m_we) check("mem_wdata", mem_wdata, m_wdata);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("checksum", checksum, m_csum);
`endif
    if (mem_we === 1'b1) begin
      cap[mem_addr] = mem_wdata;
      wr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    in_valid = 0; in_last = 0;
    repeat (n) tick();
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic set_beat(input int op, input int rs, input int rt, input int rd,
                          input int imm, input bit last);
    in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_last = last; in_valid = 1;
  endtask

  task automatic beat(input int op, input int rs, input int rt, input int rd,
                      input int imm, input bit last);
    set_beat(op, rs, rt, rd, imm, last);
    tick();
    in_valid = 0; in_last = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; in_valid = 0; in_last = 0;
    in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0;
    #1;
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_done", 32'(done), 0);
    check("rst_word_count", 32'(word_count), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    idle(2);

    // single R-type word with last
    wr_cnt = 0;
    do_start();
    beat(0, 1, 2, 3, 0, 1);
    check("t1_done_with_we", 32'({done, mem_we}), 32'h3);
    idle(2);
    check("t1_wdata", cap[0], 32'h00221820);
    check("t1_writes", 32'(wr_cnt), 1);
    check("t1_word_count", 32'(word_count), 1);
    check("t1_done", 32'(done), 1);

    // back-to-back I-type program, last beat fills the top address without overflow
    wr_cnt = 0;
    do_start();
    beat(4, 1, 2, 0, 100, 0);
    beat(7, 7, 8, 0, 24, 0);
    beat(8, 9, 10, 0, 16, 0);
    beat(10, 5, 13, 0, 'h1000, 1);
    idle(3);
    check("t2_w0", cap[0], 32'h20220064);
    check("t2_w1", cap[1], 32'hACE80018);
    check("t2_w2", cap[2], 32'h112A0010);
    check("t2_w3", cap[3], 32'h3C0D1000);
    check("t2_writes", 32'(wr_cnt), 4);
    check("t2_word_count", 32'(word_count), 4);
    check("t2_no_overflow", 32'(err_overflow), 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("t2_checksum", checksum, 32'hA1ED106C);
`endif

    // illegal code in the middle of a program
    wr_cnt = 0;
    do_start();
    beat(0, 1, 2, 3, 0, 0);
    beat(15, 1, 1, 1, 1, 0);
    beat(5, 3, 4, 0, 255, 1);
    idle(2);
    check("t3_ori", cap[1], 32'h346400FF);
    check("t3_writes", 32'(wr_cnt), 2);
    check("t3_err_illegal", 32'(err_illegal), 1);
    check("t3_word_count", 32'(word_count), 2);
    check("t3_done", 32'(done), 1);

    // overflow: four writes fill memory, the fifth beat is refused
    wr_cnt = 0;
    do_start();
    for (int i = 0; i < 4; i++) beat(1, i, i + 1, i + 2, 0, 0);
    check("t4_ready_after_full", 32'(in_ready), 0);
    check("t4_err_overflow", 32'(err_overflow), 1);
    check("t4_done", 32'(done), 1);
    beat(3, 1, 1, 1, 0, 0);
    idle(2);
    check("t4_writes", 32'(wr_cnt), 4);
    check("t4_addr_no_wrap", 32'(mem_addr), 3);
    check("t4_word_count", 32'(word_count), 4);

    // start from DONE with a simultaneous beat: start wins, beat dropped
    wr_cnt = 0;
    set_beat(2, 4, 5, 6, 0, 1);
    start = 1;
    tick();
    start = 0; in_valid = 0; in_last = 0;
    idle(1);
    check("t5_start_prio_writes", 32'(wr_cnt), 0);

    // restart mid-load clears address, count and errors
    beat(0, 1, 2, 3, 0, 0);
    beat(12, 0, 0, 0, 0, 0);
    beat(1, 4, 5, 6, 0, 0);
    do_start();
    check("t5_restart_addr", 32'(mem_addr), 0);
    check("t5_restart_count", 32'(word_count), 0);
    check("t5_restart_err", 32'(err_illegal), 0);
    beat(2, 1, 2, 3, 0, 0);
    // reset arrives while a beat is being presented
    wr_cnt = 0;
    set_beat(3, 7, 8, 9, 0, 0);
    #1 rst = 1;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_count", 32'(word_count), 0);
    @(posedge clk);
    #2;
    check("t6_rst_we", 32'(mem_we), 0);
    check("t6_rst_addr", 32'(mem_addr), 0);
    check("t6_rst_wdata", mem_wdata, 0);
    in_valid = 0;
    rst = 0;
    idle(3);
    check("t6_no_write", 32'(wr_cnt), 0);
    check("t6_idle", 32'({busy, done, in_ready}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Streams decoded-form instruction requests (mnemonic plus register/immediate fields) through a valid/ready handshake and encodes each one into a 32-bit MIPS machine word. Each word is written sequentially into instruction memory. It is the encode-and-write counterpart to `instruction_decoder`, and it sits between the test/boot sequencer and the instruction memory write port. Loads are framed by `start` and `in_last`, with sticky error reporting.

## Interface
- `ADDR_W`, default 8: instruction memory address width in words; capacity is 2^ADDR_W words.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a new load at address 0.
- `in_valid`  in  1  request beat valid.
- `in_ready`  out  1  loader accepts a beat this cycle.
- `in_op`  in  4  mnemonic code from `mips_isa_pkg`.
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register fields.
- `in_imm`  in  16  immediate field.
- `in_last`  in  1  marks the final beat of the program.
- `mem_we`  out  1  instruction memory write strobe.
- `mem_addr`  out  ADDR_W  write word address.
- `mem_wdata`  out  32  encoded instruction.
- `busy`  out  1  high in LOAD state.
- `done`  out  1  high in DONE state.
- `word_count`  out  ADDR_W+1  number of words written in the current load.
- `err_illegal`  out  1  sticky; an unknown `in_op` was received.
- `err_overflow`  out  1  sticky; memory filled before `in_last`.
- `checksum`  out  32  present only with `INSTR_LOADER_CHECKSUM_EN`.

## Operation
- Mnemonic codes and their encodings:
  - ADD=0, SUB=1, AND=2, OR=3 encode as R-type: opcode 0, shamt 0, funct 0x20, 0x22, 0x24, 0x25.
  - ADDI=4 uses opcode 0x08, ORI=5 uses 0x0D, LW=6 uses 0x23, SW=7 uses 0x2B.
  - BEQ=8 uses opcode 0x04, BNE=9 uses 0x05.
  - LUI=10 uses opcode 0x0F and forces rs=0.
  - I-type format is {opcode, rs, rt, imm}; `in_rd` is ignored.
  - Codes 11–15 are illegal.
- FSM states: IDLE, LOAD, DONE.
  - IDLE→LOAD on `start`.
  - LOAD→DONE on an accepted beat with `in_last`, or on the beat that writes address 2^ADDR_W−1.
  - DONE→LOAD on `start`.
- Entering LOAD clears `mem_addr`, `word_count`, both error flags and `checksum`.
- `in_ready` = (state == LOAD). A beat is accepted when `in_valid && in_ready`.
- Legal beat: the encoded word is registered, `mem_we` pulses for one cycle, then `mem_addr` and `word_count` increment.
- Illegal beat:
  - The beat is consumed, with no write and no address advance.
  - `err_illegal` is set.
  - If `in_last` is also asserted, the FSM still goes to DONE.
- Overflow:
  - Writing the last address without `in_last` sets `err_overflow` and moves the FSM to DONE.
  - The address does not wrap.
  - Further beats are not accepted.
- `start` during LOAD restarts the load immediately, applying the same clears. A write already in the output register still completes.
- `start` while in IDLE or DONE takes priority over any simultaneous beat; that beat is not accepted.

## Timing
- Latency: a beat accepted at edge N drives `mem_we`, `mem_addr` and `mem_wdata` registered after edge N, so they are valid during cycle N+1.
- Throughput: one word per cycle; there is no backpressure from memory.
- `done` rises on the edge after the final beat, coincident with that beat's `mem_we`.
- Reset values: every output is 0, and the FSM is in IDLE.
- Reset asserted mid-load aborts immediately; no write is issued.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - `checksum` exists.
  - It is the running XOR of every written `mem_wdata`, updated on the edge after each `mem_we` cycle.
  - It is cleared on entering LOAD and reset to 0.
- `INSTR_LOADER_CHECKSUM_EN` undefined: the `checksum` port and its logic are absent.

## Structure
- `mips_isa_pkg` holds the mnemonic enum, the opcode and funct constants, and the field width constants. The team's `instruction_decoder` uses the same package.
- Sub-module `instr_field_encoder` is purely combinational: mnemonic plus fields → {word, illegal}.
- FSM, counters and output register live in `instr_loader`.

## Test plan
- `start`, then ADD rs=1 rt=2 rd=3 with `in_last` → one `mem_we`, addr 0, wdata 0x00221820, `done`=1, `word_count`=1.
- `start`, then ADDI(1,2,100), SW(7,8,24), BEQ(9,10,16), LUI(rt=13, imm 0x1000, `in_last`) sent back-to-back:
  - Writes 0x20220064, 0xACE80018, 0x112A0010, 0x3C0D1000 to addrs 0–3.
  - `word_count`=4.
  - With the macro, `checksum` = XOR of the four words.
- ADD, op=15, ORI(3,4,255) with `in_last`:
  - Writes at addrs 0 and 1 only; the ORI word is 0x346400FF.
  - `err_illegal`=1, `word_count`=2.
- ADDR_W=2 with 5 beats and no `in_last`:
  - 4 writes, `err_overflow`=1, `done`=1.
  - The 5th beat is not accepted (`in_ready`=0).
- `start` after 2 beats of a load → `mem_addr` returns to 0, `word_count`=0 and the errors clear. Then `rst` asserted mid-beat → all outputs 0, IDLE, no `mem_we`.
